// File: rtl/data_sync_mc.sv
// rtl/data_sync_mc.sv - multi-channel enable-qualified bus synchronizer with round-robin output
//
// Destination (D_CLK) side of a MUX-select bus synchronizer for NUM_CH channels.
// Each channel's enable passes through an N_STAGES flop chain and an edge detector.
// The resulting pulse captures that channel's bus into a hold register and marks it
// pending. A round-robin arbiter drains pending channels onto a single registered
// valid/ready output.
//
// Optional feature macro: MCDS_OVF_CNT_EN (adds the ovf_cnt port and overrun counter).
//
// Ports:
//   D_CLK          in   destination clock
//   D_RST          in   asynchronous active-low reset
//   Unsync_bus     in   NUM_CH*DATA_WIDTH, channel c at [c*DATA_WIDTH +: DATA_WIDTH]
//   Unsync_enable  in   NUM_CH per-channel enable (level or toggle, see EN_MODE)
//   out_data       out  DATA_WIDTH data of the granted channel
//   out_ch         out  CH_W index of the channel in out_data
//   out_valid      out  out_data/out_ch valid
//   out_ready      in   consumer accepts when out_valid && out_ready
//   ovf_flag       out  NUM_CH sticky overrun flags
//   ovf_clr        in   clears ovf_flag (and ovf_cnt)
//   ovf_cnt        out  CNT_WIDTH saturating overrun-cycle count (MCDS_OVF_CNT_EN only)
module data_sync_mc #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_CH     = 2,
  parameter int N_STAGES   = 2,
  parameter int EN_MODE    = 0,
  parameter int CNT_WIDTH  = 8,
  localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                         D_CLK,
  input  logic                         D_RST,
  input  logic [NUM_CH*DATA_WIDTH-1:0] Unsync_bus,
  input  logic [NUM_CH-1:0]            Unsync_enable,
  output logic [DATA_WIDTH-1:0]        out_data,
  output logic [CH_W-1:0]              out_ch,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [NUM_CH-1:0]            ovf_flag,
  input  logic                         ovf_clr
`ifdef MCDS_OVF_CNT_EN
  ,
  output logic [CNT_WIDTH-1:0]         ovf_cnt
`endif
);

  if (NUM_CH < 1 || N_STAGES < 2 || DATA_WIDTH < 1 || CNT_WIDTH < 1) begin : g_bad_param
    $error("data_sync_mc: illegal parameter combination");
  end

  logic [NUM_CH-1:0][N_STAGES-1:0]   sync_q;
  logic [NUM_CH-1:0]                 s;
  logic [NUM_CH-1:0]                 s_d;
  logic [NUM_CH-1:0]                 pulse;
  logic [NUM_CH-1:0][DATA_WIDTH-1:0] hold;
  logic [NUM_CH-1:0]                 pend;
  logic [CH_W-1:0]                   ptr;

  logic                  slot_free;
  logic                  any_pend;
  logic                  drain_en;
  logic [CH_W-1:0]       grant;
  logic [CH_W-1:0]       ptr_nxt;
  logic [DATA_WIDTH-1:0] grant_data;
  logic [NUM_CH-1:0]     drained;
  logic [NUM_CH-1:0]     ovr;

  // Synchronized enable is the last flop of each chain.
  always_comb begin
    s = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      s[c] = sync_q[c][N_STAGES-1];
    end
  end

  // Level mode fires on the rising edge only; toggle mode fires on either edge.
  assign pulse = (EN_MODE == 1) ? (s ^ s_d) : (s & ~s_d);

  assign slot_free = !out_valid || out_ready;
  assign any_pend  = |pend;
  assign drain_en  = slot_free && any_pend;

  // Round-robin pick: each pending channel's distance from ptr (modulo NUM_CH) is
  // computed with constant channel indices, and the smallest distance wins.
  always_comb begin
    int best_off;
    int off;
    int nxt;
    grant      = '0;
    grant_data = '0;
    best_off   = NUM_CH;
    off        = 0;
    for (int c = 0; c < NUM_CH; c++) begin
      off = c - int'(ptr);
      if (off < 0) off = off + NUM_CH;
      if (pend[c] && off < best_off) begin
        best_off   = off;
        grant      = CH_W'(c);
        grant_data = hold[c];
      end
    end
    nxt = int'(grant) + 1;
    if (nxt >= NUM_CH) nxt = 0;
    ptr_nxt = CH_W'(nxt);
  end

  // A channel being drained this cycle may take fresh data without overrunning.
  always_comb begin
    drained = '0;
    ovr     = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      drained[c] = drain_en && (grant == CH_W'(c));
      ovr[c]     = pulse[c] && pend[c] && !drained[c];
    end
  end

  always_ff @(posedge D_CLK or negedge D_RST) begin
    if (!D_RST) begin
      sync_q    <= '0;
      s_d       <= '0;
      hold      <= '0;
      pend      <= '0;
      ptr       <= '0;
      out_data  <= '0;
      out_ch    <= '0;
      out_valid <= 1'b0;
      ovf_flag  <= '0;
    end else begin
      s_d <= s;
      for (int c = 0; c < NUM_CH; c++) begin
        sync_q[c] <= {sync_q[c][N_STAGES-2:0], Unsync_enable[c]};

        if (pulse[c] && (!pend[c] || drained[c])) begin
          hold[c] <= Unsync_bus[c*DATA_WIDTH +: DATA_WIDTH];
          pend[c] <= 1'b1;
        end else if (drained[c]) begin
          pend[c] <= 1'b0;
        end

        // A new overrun outranks a simultaneous clear.
        if (ovr[c]) begin
          ovf_flag[c] <= 1'b1;
        end else if (ovf_clr) begin
          ovf_flag[c] <= 1'b0;
        end
      end

      if (slot_free) begin
        if (any_pend) begin
          out_data  <= grant_data;
          out_ch    <= grant;
          out_valid <= 1'b1;
          ptr       <= ptr_nxt;
        end else begin
          out_valid <= 1'b0;
        end
      end
    end
  end

`ifdef MCDS_OVF_CNT_EN
  // Counts cycles with at least one overrun; clear beats increment, saturates at max.
  always_ff @(posedge D_CLK or negedge D_RST) begin
    if (!D_RST) begin
      ovf_cnt <= '0;
    end else if (ovf_clr) begin
      ovf_cnt <= '0;
    end else if ((|ovr) && (ovf_cnt != {CNT_WIDTH{1'b1}})) begin
      ovf_cnt <= ovf_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_data_sync_mc.sv
// tb/tb_data_sync_mc.sv - directed self-checking bench for data_sync_mc
module tb_data_sync_mc;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  // dut_a: level mode, 2-bit overrun counter
  logic [15:0] bus_a;
  logic [1:0]  en_a;
  logic        rdy_a;
  logic        clr_a;
  logic [7:0]  data_a;
  logic [0:0]  ch_a;
  logic        valid_a;
  logic [1:0]  ovf_a;
`ifdef MCDS_OVF_CNT_EN
  logic [1:0]  cnt_a;
`endif

  // dut_b: toggle mode
  logic [15:0] bus_b;
  logic [1:0]  en_b;
  logic        rdy_b;
  logic        clr_b;
  logic [7:0]  data_b;
  logic [0:0]  ch_b;
  logic        valid_b;
  logic [1:0]  ovf_b;
`ifdef MCDS_OVF_CNT_EN
  logic [7:0]  cnt_b;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  data_sync_mc #(.DATA_WIDTH(8), .NUM_CH(2), .N_STAGES(2), .EN_MODE(0), .CNT_WIDTH(2)) dut_a (
    .D_CLK(clk),
    .D_RST(rst_n),
    .Unsync_bus(bus_a),
    .Unsync_enable(en_a),
    .out_data(data_a),
    .out_ch(ch_a),
    .out_valid(valid_a),
    .out_ready(rdy_a),
    .ovf_flag(ovf_a),
    .ovf_clr(clr_a)
`ifdef MCDS_OVF_CNT_EN
    ,
    .ovf_cnt(cnt_a)
`endif
  );

  data_sync_mc #(.DATA_WIDTH(8), .NUM_CH(2), .N_STAGES(2), .EN_MODE(1), .CNT_WIDTH(8)) dut_b (
    .D_CLK(clk),
    .D_RST(rst_n),
    .Unsync_bus(bus_b),
    .Unsync_enable(en_b),
    .out_data(data_b),
    .out_ch(ch_b),
    .out_valid(valid_b),
    .out_ready(rdy_b),
    .ovf_flag(ovf_b),
    .ovf_clr(clr_b)
`ifdef MCDS_OVF_CNT_EN
    ,
    .ovf_cnt(cnt_b)
`endif
  );

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus_a = '0; en_a = '0; rdy_a = 1'b0; clr_a = 1'b0;
    bus_b = '0; en_b = '0; rdy_b = 1'b0; clr_b = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(1);
  endtask

  task automatic send_a(input int ch, input logic [7:0] val);
    bus_a[ch*8 +: 8] = val;
    en_a[ch] = 1'b1;
    tick(4);
    en_a[ch] = 1'b0;
    tick(4);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus_a = 16'hFFFF; en_a = '0; rdy_a = 1'b1; clr_a = 1'b0;
    bus_b = 16'hFFFF; en_b = '0; rdy_b = 1'b1; clr_b = 1'b0;
    tick(2);
    n_checks++;
    if (valid_a !== 1'b0) begin n_fail++; $display("FAIL reset_valid_a: got %0b want 0", valid_a); end
    n_checks++;
    if (data_a !== 8'h00) begin n_fail++; $display("FAIL reset_data_a: got %02h want 00", data_a); end
    n_checks++;
    if (ch_a !== 1'b0) begin n_fail++; $display("FAIL reset_ch_a: got %0d want 0", ch_a); end
    n_checks++;
    if (ovf_a !== 2'b00) begin n_fail++; $display("FAIL reset_ovf_a: got %02b want 00", ovf_a); end
    n_checks++;
    if (valid_b !== 1'b0) begin n_fail++; $display("FAIL reset_valid_b: got %0b want 0", valid_b); end
`ifdef MCDS_OVF_CNT_EN
    n_checks++;
    if (cnt_a !== 2'd0) begin n_fail++; $display("FAIL reset_cnt_a: got %0d want 0", cnt_a); end
`endif
  endtask

  task automatic test_latency();
    do_reset();
    rdy_a = 1'b1;
    bus_a[7:0] = 8'hA5;
    en_a[0] = 1'b1;
    tick(3);
    n_checks++;
    if (valid_a !== 1'b0) begin n_fail++; $display("FAIL lat_early: valid got %0b want 0", valid_a); end
    tick(1);
    n_checks++;
    if (valid_a !== 1'b1 || data_a !== 8'hA5 || ch_a !== 1'b0) begin
      n_fail++;
      $display("FAIL lat_out: got v=%0b d=%02h ch=%0d want v=1 d=a5 ch=0", valid_a, data_a, ch_a);
    end
    tick(1);
    n_checks++;
    if (valid_a !== 1'b0) begin n_fail++; $display("FAIL lat_drop: valid got %0b want 0", valid_a); end
    en_a[0] = 1'b0;
    tick(4);
  endtask

  task automatic test_round_robin();
    do_reset();
    rdy_a = 1'b1;
    bus_a = {8'h22, 8'h11};
    en_a = 2'b11;
    tick(4);
    n_checks++;
    if (valid_a !== 1'b1 || data_a !== 8'h11 || ch_a !== 1'b0) begin
      n_fail++;
      $display("FAIL rr_first: got v=%0b d=%02h ch=%0d want v=1 d=11 ch=0", valid_a, data_a, ch_a);
    end
    tick(1);
    n_checks++;
    if (valid_a !== 1'b1 || data_a !== 8'h22 || ch_a !== 1'b1) begin
      n_fail++;
      $display("FAIL rr_second: got v=%0b d=%02h ch=%0d want v=1 d=22 ch=1", valid_a, data_a, ch_a);
    end
    tick(1);
    n_checks++;
    if (valid_a !== 1'b0) begin n_fail++; $display("FAIL rr_idle: valid got %0b want 0", valid_a); end
    en_a = 2'b00;
    tick(4);
    bus_a = {8'h88, 8'h77};
    en_a = 2'b11;
    tick(4);
    n_checks++;
    if (valid_a !== 1'b1 || data_a !== 8'h77 || ch_a !== 1'b0) begin
      n_fail++;
      $display("FAIL rr_wrap_first: got v=%0b d=%02h ch=%0d want v=1 d=77 ch=0", valid_a, data_a, ch_a);
    end
    tick(1);
    n_checks++;
    if (valid_a !== 1'b1 || data_a !== 8'h88 || ch_a !== 1'b1) begin
      n_fail++;
      $display("FAIL rr_wrap_second: got v=%0b d=%02h ch=%0d want v=1 d=88 ch=1", valid_a, data_a, ch_a);
    end
    en_a = 2'b00;
    tick(4);
  endtask

  task automatic test_overrun();
    do_reset();
    rdy_a = 1'b0;
    send_a(0, 8'h33);
    n_checks++;
    if (valid_a !== 1'b1 || data_a !== 8'h33) begin
      n_fail++;
      $display("FAIL ovr_hold33: got v=%0b d=%02h want v=1 d=33", valid_a, data_a);
    end
    send_a(0, 8'h44);
    n_checks++;
    if (ovf_a !== 2'b00 || data_a !== 8'h33) begin
      n_fail++;
      $display("FAIL ovr_pend44: got ovf=%02b d=%02h want ovf=00 d=33", ovf_a, data_a);
    end
    send_a(0, 8'h55);
    n_checks++;
    if (ovf_a !== 2'b01 || data_a !== 8'h33 || valid_a !== 1'b1) begin
      n_fail++;
      $display("FAIL ovr_flag: got ovf=%02b d=%02h v=%0b want ovf=01 d=33 v=1", ovf_a, data_a, valid_a);
    end
    rdy_a = 1'b1;
    tick(1);
    n_checks++;
    if (valid_a !== 1'b1 || data_a !== 8'h44 || ch_a !== 1'b0) begin
      n_fail++;
      $display("FAIL ovr_drain44: got v=%0b d=%02h ch=%0d want v=1 d=44 ch=0", valid_a, data_a, ch_a);
    end
    tick(1);
    n_checks++;
    if (valid_a !== 1'b0) begin n_fail++; $display("FAIL ovr_no55: valid got %0b want 0", valid_a); end
    clr_a = 1'b1;
    tick(1);
    clr_a = 1'b0;
    n_checks++;
    if (ovf_a !== 2'b00) begin n_fail++; $display("FAIL ovr_clr: got %02b want 00", ovf_a); end
  endtask

  task automatic test_toggle_mode();
    do_reset();
    rdy_b = 1'b1;
    bus_b[7:0] = 8'h0F;
    en_b[0] = 1'b1;
    tick(4);
    n_checks++;
    if (valid_b !== 1'b1 || data_b !== 8'h0F || ch_b !== 1'b0) begin
      n_fail++;
      $display("FAIL tog_rise: got v=%0b d=%02h ch=%0d want v=1 d=0f ch=0", valid_b, data_b, ch_b);
    end
    tick(1);
    n_checks++;
    if (valid_b !== 1'b0) begin n_fail++; $display("FAIL tog_gap: valid got %0b want 0", valid_b); end
    bus_b[7:0] = 8'hF0;
    en_b[0] = 1'b0;
    tick(4);
    n_checks++;
    if (valid_b !== 1'b1 || data_b !== 8'hF0) begin
      n_fail++;
      $display("FAIL tog_fall: got v=%0b d=%02h want v=1 d=f0", valid_b, data_b);
    end
    tick(1);
    n_checks++;
    if (valid_b !== 1'b0) begin n_fail++; $display("FAIL tog_end: valid got %0b want 0", valid_b); end
  endtask

  task automatic test_async_reset();
    int bad;
    do_reset();
    rdy_a = 1'b0;
    send_a(0, 8'h12);
    send_a(0, 8'h34);
    send_a(0, 8'h56);
    n_checks++;
    if (valid_a !== 1'b1 || ovf_a !== 2'b01) begin
      n_fail++;
      $display("FAIL arst_pre: got v=%0b ovf=%02b want v=1 ovf=01", valid_a, ovf_a);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (valid_a !== 1'b0 || data_a !== 8'h00 || ch_a !== 1'b0 || ovf_a !== 2'b00) begin
      n_fail++;
      $display("FAIL arst_immediate: got v=%0b d=%02h ch=%0d ovf=%02b want all 0", valid_a, data_a, ch_a, ovf_a);
    end
    tick(1);
    rst_n = 1'b1;
    en_a = 2'b00;
    rdy_a = 1'b1;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (valid_a !== 1'b0) bad++;
    end
    n_checks++;
    if (bad != 0) begin n_fail++; $display("FAIL arst_quiet: valid high in %0d of 20 cycles, want 0", bad); end
  endtask

`ifdef MCDS_OVF_CNT_EN
  task automatic test_ovf_cnt();
    do_reset();
    rdy_a = 1'b0;
    send_a(0, 8'h01);
    send_a(0, 8'h02);
    send_a(0, 8'h03);
    n_checks++;
    if (cnt_a !== 2'd1) begin n_fail++; $display("FAIL cnt_one: got %0d want 1", cnt_a); end
    for (int k = 0; k < 4; k++) send_a(0, 8'h10 + 8'(k));
    n_checks++;
    if (cnt_a !== 2'd3) begin n_fail++; $display("FAIL cnt_sat: got %0d want 3", cnt_a); end
    bus_a[7:0] = 8'hEE;
    en_a[0] = 1'b1;
    tick(2);
    clr_a = 1'b1;
    tick(1);
    clr_a = 1'b0;
    n_checks++;
    if (cnt_a !== 2'd0 || ovf_a !== 2'b01) begin
      n_fail++;
      $display("FAIL cnt_clr_race: got cnt=%0d ovf=%02b want cnt=0 ovf=01", cnt_a, ovf_a);
    end
    en_a[0] = 1'b0;
    tick(4);
  endtask
`endif

  initial begin
    test_reset();
    test_latency();
    test_round_robin();
    test_overrun();
    test_toggle_mode();
    test_async_reset();
`ifdef MCDS_OVF_CNT_EN
    test_ovf_cnt();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
